seg_msg_scroller: RTL and testbench

Parametrised successor to the fixed-message birthday display. It holds a run-time-loadable message of 7-segment glyphs and drives a NUM_DIGITS-wide display window. The window can be static, scroll left, scroll right or blink, stepping at a prescaled tick rate. It sits between the board controller (message load, start/stop, pause) and the 7-segment digit drivers. Segment encoding is active-low, the same as the existing glyph constants.

---
 rtl/seg_msg_scroller_pkg.sv | 29 ++
 rtl/seg_msg_scroller_if.sv | 38 +++
 rtl/seg_msg_scroller_tick.sv | 34 +++
 rtl/seg_msg_scroller.sv | 143 ++++++++++++++
 tb/tb_seg_msg_scroller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_msg_scroller_pkg.sv
// Shared glyph package for the 7-segment message blocks.
// Segment bits are {g,f,e,d,c,b,a} and active-low, so 0 means the segment is lit.
package seg_msg_scroller_pkg;

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_LEFT   = 2'd1,
    M_RIGHT  = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SC_IDLE = 2'd0,
    SC_RUN  = 2'd1,
    SC_HOLD = 2'd2
  } scr_state_t;

  localparam logic [6:0] BLANK   = 7'h7F;
  localparam logic [6:0] GLYPH_H = 7'b0001001;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_P = 7'b0001100;
  localparam logic [6:0] GLYPH_Y = 7'b0010001;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_D = 7'b0100001;

  // Value loaded into every message buffer entry on reset (all segments off).
  localparam logic [6:0] BUF_RST = 7'b1111111;

endpackage

// File: rtl/seg_msg_scroller_if.sv
// Control/display bundle between the board controller and the scroller.
// start/stop/pause are single-cycle pulses with no handshake: the scroller
// samples them on every rising clock edge and never back-pressures. wr_en is
// a write strobe accepted in the same cycle it is high.
interface seg_msg_scroller_if
  import seg_msg_scroller_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_LEN    = 16
) ();

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  logic                    start;
  logic                    stop;
  logic                    pause;
  mode_t                   mode;
  logic [LW-1:0]           msg_len;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [6:0]              wr_data;
  logic [NUM_DIGITS*7-1:0] seg;
  logic                    busy;
  logic                    wrap;
  scr_state_t              state;   // debug view of the scroller FSM

  modport master (
    output start, stop, pause, mode, msg_len, wr_en, wr_addr, wr_data,
    input  seg, busy, wrap, state
  );

  modport slave (
    input  start, stop, pause, mode, msg_len, wr_en, wr_addr, wr_data,
    output seg, busy, wrap, state
  );

endinterface

// File: rtl/seg_msg_scroller_tick.sv
// Display-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count as a one-cycle tick. Holds its count while disabled.
module seg_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_max;

  assign at_max = (cnt_q == CW'(TICK_DIV - 1));
  assign tick_o = en_i && !clr_i && at_max;

  // Next count: clear wins, otherwise advance and roll over while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = at_max ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// Run-time loadable 7-segment message scroller. Holds up to MAX_LEN glyphs and
// shows a NUM_DIGITS window that is static, scrolls left/right or blinks.
// seg/busy are registered from next-state values so a start or step shows on
// the display one cycle later; buffer writes take one extra cycle.
module seg_msg_scroller
  import seg_msg_scroller_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_LEN    = 16,
  parameter int TICK_DIV   = 50_000_000
) (
  input logic             clk,
  input logic             rst,
  seg_msg_scroller_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);

  scr_state_t              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [LW-1:0]           len_q, len_d;
  mode_t                   mode_q, mode_d;
  logic                    blank_q, blank_d;
  logic                    wrap_q, wrap_d;
  logic                    busy_q;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
  logic [6:0]              buf_q [MAX_LEN];
  logic                    start_ok, tick, tick_clr, ptr_last;
  logic [PW-1:0]           idx;

  assign start_ok = bus.start && (bus.msg_len != '0) && (int'(bus.msg_len) <= MAX_LEN);
  assign tick_clr = bus.stop || start_ok;
  assign ptr_last = (LW'(ptr_q) == len_q - LW'(1));

  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == SC_RUN),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Next state: stop > start > pause; a tick steps the pointer using the
  // mode latched at the previous step boundary, then latches the live mode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    wrap_d  = 1'b0;
    if (bus.stop) begin
      state_d = SC_IDLE;
    end else if (start_ok) begin
      state_d = SC_RUN;
      len_d   = bus.msg_len;
      mode_d  = bus.mode;
      ptr_d   = '0;
      blank_d = 1'b0;
    end else begin
      if (bus.pause) begin
        if (state_q == SC_RUN)       state_d = SC_HOLD;
        else if (state_q == SC_HOLD) state_d = SC_RUN;
      end
      if (tick) begin
        mode_d = bus.mode;
        case (mode_q)
          M_LEFT: begin
            if (ptr_last) begin
              ptr_d  = '0;
              wrap_d = (len_q != LW'(1));
            end else begin
              ptr_d = ptr_q + PW'(1);
            end
          end
          M_RIGHT: begin
            if (ptr_q == '0) begin
              ptr_d  = PW'(len_q - LW'(1));
              wrap_d = (len_q != LW'(1));
            end else begin
              ptr_d = ptr_q - PW'(1);
            end
          end
          M_BLINK: blank_d = ~blank_q;
          default: ;
        endcase
      end
    end
  end

  // Window: walk the buffer from ptr_d, wrapping at len_d by compare-and-reset
  // so short messages repeat across the digits without a divider.
  always_comb begin
    seg_d = {NUM_DIGITS{BLANK}};
    idx   = ptr_d;
    if (state_d != SC_IDLE && !blank_d) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_d[7*i +: 7] = buf_q[idx];
        if (LW'(idx) == len_d - LW'(1)) idx = '0;
        else                            idx = idx + PW'(1);
      end
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SC_IDLE;
      ptr_q   <= '0;
      len_q   <= LW'(1);
      mode_q  <= M_STATIC;
      blank_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= {NUM_DIGITS{BLANK}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d != SC_IDLE);
      seg_q   <= seg_d;
    end
  end

  // Message buffer; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++) buf_q[k] <= BUF_RST;
    end else if (bus.wr_en && (int'(bus.wr_addr) < MAX_LEN)) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.busy  = busy_q;
  assign bus.wrap  = wrap_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Bench for seg_msg_scroller: directed scenarios plus randomized traffic, with
// a cycle reference model that derives the window by modular arithmetic.
module tb_seg_msg_scroller;
  import seg_msg_scroller_pkg::*;

  localparam int ND = 4;
  localparam int ML = 16;
  localparam int TD = 4;
  localparam int SW = ND * 7;
  localparam logic [SW-1:0] ALL_BLANK = {ND{7'h7F}};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_msg_scroller_if #(.NUM_DIGITS(ND), .MAX_LEN(ML)) ifc ();

  seg_msg_scroller #(.NUM_DIGITS(ND), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // reference model state
  int            m_st;      // 0 idle, 1 run, 2 hold
  int            m_cnt, m_ptr, m_len, m_mode, m_blank;
  logic [6:0]    m_buf [ML];
  logic [SW-1:0] exp_seg;
  logic          exp_busy, exp_wrap;
  int            n_tests, n_fail, wrap_seen;

  function automatic logic [SW-1:0] pack4(logic [6:0] d0, logic [6:0] d1,
                                          logic [6:0] d2, logic [6:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_ptr = 0; m_len = 1; m_mode = 0; m_blank = 0;
    for (int k = 0; k < ML; k++) m_buf[k] = 7'h7F;
    exp_seg = ALL_BLANK; exp_busy = 1'b0; exp_wrap = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs presented to the DUT.
  task automatic model_edge();
    bit start_ok, tick;
    int d_len;
    d_len    = int'(ifc.msg_len);
    start_ok = ifc.start && d_len >= 1 && d_len <= ML;
    tick     = (m_st == 1) && (m_cnt == TD - 1) && !ifc.stop && !start_ok;
    exp_wrap = 1'b0;
    if (ifc.stop) begin
      m_st = 0; m_cnt = 0;
    end else if (start_ok) begin
      m_st = 1; m_len = d_len; m_mode = int'(ifc.mode);
      m_ptr = 0; m_blank = 0; m_cnt = 0;
    end else begin
      if (m_st == 1) m_cnt = (m_cnt + 1) % TD;
      if (tick) begin
        case (m_mode)
          1: begin m_ptr = (m_ptr + 1) % m_len;         exp_wrap = (m_ptr == 0) && (m_len > 1); end
          2: begin m_ptr = (m_ptr + m_len - 1) % m_len; exp_wrap = (m_ptr == m_len - 1) && (m_len > 1); end
          3: m_blank = 1 - m_blank;
          default: ;
        endcase
        m_mode = int'(ifc.mode);
      end
      if (ifc.pause) m_st = (m_st == 1) ? 2 : (m_st == 2) ? 1 : m_st;
    end
    exp_busy = (m_st != 0);
    exp_seg  = ALL_BLANK;
    if (m_st != 0 && m_blank == 0)
      for (int i = 0; i < ND; i++) exp_seg[7*i +: 7] = m_buf[(m_ptr + i) % m_len];
    if (ifc.wr_en && int'(ifc.wr_addr) < ML) m_buf[ifc.wr_addr] = ifc.wr_data;
  endtask

  task automatic chk(string tag, logic [SW-1:0] got, logic [SW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("seg",  ifc.seg, exp_seg);
    chk("busy", SW'(ifc.busy), SW'(exp_busy));
    chk("wrap", SW'(ifc.wrap), SW'(exp_wrap));
  endtask

  // driver: consume n clock edges, check every cycle, drop one-cycle pulses
  task automatic cyc(int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      wrap_seen += int'(ifc.wrap);
      ifc.start = 1'b0; ifc.stop = 1'b0; ifc.pause = 1'b0; ifc.wr_en = 1'b0;
    end
  endtask

  task automatic wr(int a, logic [6:0] d);
    ifc.wr_en = 1'b1; ifc.wr_addr = 4'(a); ifc.wr_data = d;
    cyc(1);
  endtask

  task automatic do_start(int len, mode_t md);
    ifc.msg_len = 5'(len); ifc.mode = md; ifc.start = 1'b1;
    cyc(1);
  endtask

  initial begin
    logic [6:0] msg [11];
    msg = '{GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P, GLYPH_Y, BLANK,
            GLYPH_B, GLYPH_D, GLYPH_A, GLYPH_Y, BLANK};
    n_tests = 0; n_fail = 0; wrap_seen = 0;
    ifc.start = 0; ifc.stop = 0; ifc.pause = 0; ifc.mode = M_STATIC;
    ifc.msg_len = '0; ifc.wr_en = 0; ifc.wr_addr = '0; ifc.wr_data = '0;
    model_reset();

    // reset state
    #12;
    chk("rst_seg",  ifc.seg, ALL_BLANK);
    chk("rst_busy", SW'(ifc.busy), '0);
    chk("rst_wrap", SW'(ifc.wrap), '0);
    #10 rst = 1'b0;

    // scroll left over the birthday message
    for (int a = 0; a < 11; a++) wr(a, msg[a]);
    do_start(11, M_LEFT);
    chk("left_first", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P));
    wrap_seen = 0;
    cyc(4);
    chk("left_tick1", ifc.seg, pack4(GLYPH_A, GLYPH_P, GLYPH_P, GLYPH_Y));
    cyc(40);
    chk("left_tick11", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P));
    chk("left_wraps", SW'(wrap_seen), SW'(1));

    // scroll right restarted from RUN
    do_start(11, M_RIGHT);
    cyc(4);
    chk("right_tick1", ifc.seg, pack4(BLANK, GLYPH_H, GLYPH_A, GLYPH_P));
    chk("right_wrap",  SW'(ifc.wrap), SW'(1));
    chk("right_busy",  SW'(ifc.busy), SW'(1));
    cyc(12);

    // static, two-glyph message repeats across the window
    do_start(2, M_STATIC);
    chk("static_win", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_H, GLYPH_A));
    wrap_seen = 0;
    cyc(40);
    chk("static_hold", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_H, GLYPH_A));
    chk("static_nowrap", SW'(wrap_seen), '0);

    // blink with pause/resume keeping the prescaler count
    do_start(4, M_BLINK);
    chk("blink_on", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P));
    cyc(4);
    chk("blink_off", ifc.seg, ALL_BLANK);
    cyc(2);
    ifc.pause = 1'b1; cyc(1);
    cyc(9);
    chk("blink_frozen", ifc.seg, ALL_BLANK);
    ifc.pause = 1'b1; cyc(1);
    chk("blink_resume0", ifc.seg, ALL_BLANK);
    cyc(1);
    chk("blink_resume1", ifc.seg, pack4(GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P));

    // zero-length start ignored, stop, start+stop together
    ifc.stop = 1'b1; cyc(1);
    do_start(0, M_LEFT);
    cyc(3);
    chk("len0_busy", SW'(ifc.busy), '0);
    chk("len0_seg",  ifc.seg, ALL_BLANK);
    do_start(4, M_LEFT);
    cyc(3);
    ifc.stop = 1'b1; cyc(1);
    chk("stop_seg",  ifc.seg, ALL_BLANK);
    chk("stop_busy", SW'(ifc.busy), '0);
    ifc.msg_len = 5'd4; ifc.start = 1'b1; ifc.stop = 1'b1; cyc(1);
    chk("startstop_busy", SW'(ifc.busy), '0);

    // randomized traffic against the model
    for (int t = 0; t < 10; t++) begin
      int len;
      len = $urandom_range(1, ML);
      for (int a = 0; a < len; a++) wr(a, 7'($urandom));
      ifc.mode    = mode_t'($urandom_range(0, 3));
      ifc.msg_len = (t == 3) ? 5'd0 : (t == 6) ? 5'd17 : 5'(len);
      ifc.start   = 1'b1;
      cyc(1);
      for (int c = 0; c < 48; c++) begin
        if ($urandom_range(0, 9) == 0) ifc.pause = 1'b1;
        if ($urandom_range(0, 7) == 0) ifc.mode = mode_t'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
          ifc.wr_en = 1'b1; ifc.wr_addr = 4'($urandom_range(0, ML - 1)); ifc.wr_data = 7'($urandom);
        end
        if ($urandom_range(0, 59) == 0) ifc.stop = 1'b1;
        cyc(1);
      end
    end

    // asynchronous reset in the middle of a scroll
    for (int a = 0; a < 11; a++) wr(a, msg[a]);
    do_start(11, M_LEFT);
    cyc(6);
    #3 rst = 1'b1;
    #1;
    chk("arst_seg",  ifc.seg, ALL_BLANK);
    chk("arst_busy", SW'(ifc.busy), '0);
    chk("arst_wrap", SW'(ifc.wrap), '0);
    model_reset();
    #10 rst = 1'b0;
    do_start(4, M_STATIC);
    chk("arst_bufblank", ifc.seg, ALL_BLANK);
    chk("arst_busy_on",  SW'(ifc.busy), SW'(1));
    cyc(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
